// File: rtl/regfile_dump.sv
// Walks register-file addresses 0..LAST_ADDR through a single read port and
// streams each (address, value) pair out over a valid/ready handshake.
module regfile_dump #(
  parameter logic [3:0] LAST_ADDR = 4'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_addr,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        out_valid_reg, out_valid_next;
  logic [3:0]  out_addr_reg, out_addr_next;
  logic [15:0] out_data_reg, out_data_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      out_valid_reg <= 1'b0;
      out_addr_reg  <= 4'd0;
      out_data_reg  <= 16'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      out_addr_reg  <= out_addr_next;
      out_data_reg  <= out_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    out_addr_next  = out_addr_reg;
    out_data_next  = out_data_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          cnt_next   = 4'd0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        // The register is sampled here and only here, so later writes
        // cannot disturb a beat already presented to the consumer.
        out_data_next  = rd_data;
        out_addr_next  = cnt_reg;
        out_valid_next = 1'b1;
        state_next     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          if (cnt_reg == LAST_ADDR) begin
            state_next = DONE;
          end else begin
            cnt_next   = cnt_reg + 4'd1;
            state_next = FETCH;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rd_addr   = cnt_reg;
  assign out_valid = out_valid_reg;
  assign out_addr  = out_addr_reg;
  assign out_data  = out_data_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: stimulus queues expected beats, a
// negedge monitor pops and checks them, plus done/busy timing and hold stability.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0, ready0 = 1'b1;
  logic [3:0]  ra0, ra1, oa0, oa1;
  logic [15:0] rd0, rd1, od0, od1;
  logic        ov0, ov1, busy0, busy1, done0, done1;

  logic [15:0] regs  [16];
  logic [15:0] model [16];

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct {
    int          inst;
    logic [3:0]  addr;
    logic [15:0] data;
    bit          last;
  } beat_t;
  beat_t exp_q[$];

  int start_edge[2] = '{-10, -10};

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  assign rd0 = regs[ra0];
  assign rd1 = regs[ra1];

  regfile_dump dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .rd_addr(ra0), .rd_data(rd0),
    .out_valid(ov0), .out_ready(ready0), .out_addr(oa0), .out_data(od0),
    .busy(busy0), .done(done0)
  );

  regfile_dump #(.LAST_ADDR(4'd3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rd_addr(ra1), .rd_data(rd1),
    .out_valid(ov1), .out_ready(1'b1), .out_addr(oa1), .out_data(od1),
    .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // ---------------- monitor ----------------
  bit          in_beat  [2] = '{0, 0};
  bit          cur_last [2] = '{0, 0};
  logic [3:0]  h_addr   [2];
  logic [15:0] h_data   [2];
  int          trig_edge[2] = '{-10, -10};
  int          done_due [2] = '{-10, -10};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic        v, r, d, b;
      logic [3:0]  a;
      logic [15:0] dat;
      beat_t       e;
      int          ref_e;
      v   = (i == 0) ? ov0   : ov1;
      r   = (i == 0) ? ready0 : 1'b1;
      d   = (i == 0) ? done0 : done1;
      b   = (i == 0) ? busy0 : busy1;
      a   = (i == 0) ? oa0   : oa1;
      dat = (i == 0) ? od0   : od1;
      if (!rst_n) begin
        in_beat[i]  = 0;
        done_due[i] = -10;
      end else begin
        chk($sformatf("done_inst%0d", i), d, edge_n == done_due[i]);
        if (edge_n == done_due[i] + 1)
          chk($sformatf("busy_after_done_inst%0d", i), b, 1'b0);
        if (v) begin
          if (!in_beat[i]) begin
            if (exp_q.size() == 0 || exp_q[0].inst != i) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat inst %0d: got addr %0h data %0h expected none", i, a, dat);
              cur_last[i] = 0;
            end else begin
              e = exp_q.pop_front();
              $display("beat inst %0d addr %0d data %04h (expect %0d %04h)", i, a, dat, e.addr, e.data);
              chk("beat_addr", a, e.addr);
              chk("beat_data", dat, e.data);
              ref_e = (start_edge[i] > trig_edge[i]) ? start_edge[i] : trig_edge[i];
              chk("beat_latency", edge_n - ref_e, 1);
              cur_last[i] = e.last;
            end
            in_beat[i] = 1;
            h_addr[i]  = a;
            h_data[i]  = dat;
          end else begin
            chk("hold_addr", a, h_addr[i]);
            chk("hold_data", dat, h_data[i]);
          end
          if (r) begin
            in_beat[i]   = 0;
            trig_edge[i] = edge_n + 1;
            if (cur_last[i]) done_due[i] = edge_n + 1;
          end
        end else if (in_beat[i]) begin
          checks++;
          errors++;
          $display("FAIL valid_dropped inst %0d: got out_valid 0 expected 1", i);
          in_beat[i] = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input int i, input int last);
    for (int k = 0; k <= last; k++) begin
      beat_t e;
      e.inst = i;
      e.addr = 4'(k);
      e.data = model[k];
      e.last = (k == last);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input int i);
    if (i == 0) start0 = 1'b1; else start1 = 1'b1;
    start_edge[i] = edge_n + 1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while ((exp_q.size() != 0 || ((i == 0) ? busy0 : busy1)) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) timeout_fail("wait_idle");
  endtask

  task automatic wait_beat(input int k);
    int n = 0;
    while (!(ov0 && oa0 == 4'(k)) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) timeout_fail("wait_beat");
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, ov0, 0);
    chk({tag, "_addr"}, oa0, 0);
    chk({tag, "_data"}, od0, 0);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_rd_addr"}, ra0, 0);
    chk({tag, "_busy3"}, busy1, 0);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 16; k++) begin
      regs[k]  = 16'hA000 + 16'(k);
      model[k] = 16'hA000 + 16'(k);
    end
    #2 rst_n = 1'b0;
    #1 chk_zero("por");
    tick();
    tick();
    chk_zero("por_hold");
    rst_n = 1'b1;
    tick();

    // full dump, consumer always ready
    push_dump(0, 15);
    do_start(0);
    wait_idle(0);

    // backpressure on beat 3, ignored start at beat 5
    push_dump(0, 15);
    do_start(0);
    n = 0;
    while (!(busy0 && !ov0 && ra0 == 4'd3) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) timeout_fail("wait_fetch3");
    ready0 = 1'b0;
    repeat (5) tick();
    ready0 = 1'b1;
    wait_beat(5);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n = 0;
    while (!done0 && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) timeout_fail("wait_done");
    tick();

    // restart one cycle after done; writes while beat 8 is held
    model[10] = 16'h1234;
    push_dump(0, 15);
    do_start(0);
    wait_beat(8);
    ready0 = 1'b0;
    regs[10] = 16'h1234;
    regs[8]  = 16'hBEEF;
    repeat (3) tick();
    ready0 = 1'b1;
    wait_idle(0);
    regs[8]   = 16'hA008;
    regs[10]  = 16'hA00A;
    model[10] = 16'hA00A;

    // reset while beat 7 is valid
    push_dump(0, 15);
    do_start(0);
    wait_beat(7);
    rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    push_dump(0, 15);
    do_start(0);
    wait_idle(0);

    // random register contents and random backpressure
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 16; k++) begin
        regs[k]  = 16'($urandom);
        model[k] = regs[k];
      end
      repeat ($urandom_range(0, 3)) tick();
      push_dump(0, 15);
      do_start(0);
      n = 0;
      while ((exp_q.size() != 0 || busy0) && n < 3000) begin
        ready0 = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      if (n >= 3000) timeout_fail("random_dump");
      ready0 = 1'b1;
    end

    // short dump on the LAST_ADDR=3 instance
    push_dump(1, 3);
    do_start(1);
    wait_idle(1);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
